serial_w_gen: RTL and testbench

Serial stimulus transmitter for the Moore `w`/`z` sequence-detector control path. It loads a parallel bit pattern and shifts it out one bit per clock on a single `w` line, with a load/busy/done handshake. It sits upstream of the detector's `w` input and replaces hand-written per-bit stimulus. An optional built-in reference model predicts the detector's `z` output.

---
 rtl/serial_w_gen.sv | 156 +++++++++++++++
 tb/tb_serial_w_gen.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/serial_w_gen.sv
// Serial w-stream transmitter: loads a pattern and shifts it out LSB first.
// Optional Moore reference model (EXPECT_Z_EN) predicts the detector z output.
//
// Ports:
//   inputClk, inputReset     clock, async active-high reset
//   inputLoad                start request (accepted only when idle)
//   inputPattern             bits to send, LSB first
//   inputLength              bit count, clamped to WIDTH
//   outputW, outputValid     serial bit and its qualifier
//   outputBusy, outputDone   transfer in progress / one-cycle end pulse
//   outputExpZ               predicted detector z (EXPECT_Z_EN)
//   outputMatchCount         predicted z rising edges since load (EXPECT_Z_EN)
module serial_w_gen #(
  parameter int WIDTH = 16,
  parameter int LEN_W = 5
) (
  input  logic             inputClk,
  input  logic             inputReset,
  input  logic             inputLoad,
  input  logic [WIDTH-1:0] inputPattern,
  input  logic [LEN_W-1:0] inputLength,
  output logic             outputW,
  output logic             outputValid,
  output logic             outputBusy,
  output logic             outputDone,
  output logic             outputExpZ,
  output logic [7:0]       outputMatchCount
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_nx;
  logic [LEN_W-1:0] cnt;
  logic [LEN_W-1:0] cnt_nx;
  logic [LEN_W-1:0] len_clamp;
  logic             load_ok;

  logic w_nx;
  logic valid_nx;
  logic busy_nx;
  logic done_nx;

  assign len_clamp = (inputLength > LEN_W'(WIDTH))
                   ? LEN_W'(WIDTH) : inputLength;
  assign load_ok   = (state == IDLE) && inputLoad;

  always_ff @(posedge inputClk or posedge inputReset) begin
    if (inputReset) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      shreg <= shreg_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    shreg_nx = shreg;
    cnt_nx   = cnt;
    unique case (state)
      IDLE: begin
        if (load_ok) begin
          shreg_nx = inputPattern;
          cnt_nx   = len_clamp;
          state_nx = (len_clamp == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        shreg_nx = shreg >> 1;
        cnt_nx   = cnt - 1'b1;
        if (cnt <= LEN_W'(1)) state_nx = DONE;
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Outputs are computed from the next state so they can be registered
  // without adding a cycle of latency.
  always_comb begin
    w_nx     = (state_nx == SHIFT) && shreg_nx[0];
    valid_nx = (state_nx == SHIFT);
    busy_nx  = (state_nx != IDLE);
    done_nx  = (state_nx == DONE);
  end

  always_ff @(posedge inputClk or posedge inputReset) begin
    if (inputReset) begin
      outputW     <= 1'b0;
      outputValid <= 1'b0;
      outputBusy  <= 1'b0;
      outputDone  <= 1'b0;
    end else begin
      outputW     <= w_nx;
      outputValid <= valid_nx;
      outputBusy  <= busy_nx;
      outputDone  <= done_nx;
    end
  end

`ifdef EXPECT_Z_EN
  typedef enum logic [1:0] {
    MA,
    MB,
    MC
  } m_t;

  m_t m;
  m_t m_nx;

  always_comb begin
    m_nx = MA;
    if (outputW) begin
      unique case (m)
        MA:      m_nx = MB;
        MB:      m_nx = MC;
        MC:      m_nx = MC;
        default: m_nx = MA;
      endcase
    end
  end

  always_ff @(posedge inputClk or posedge inputReset) begin
    if (inputReset) begin
      m                <= MA;
      outputExpZ       <= 1'b0;
      outputMatchCount <= '0;
    end else begin
      m          <= m_nx;
      outputExpZ <= (m_nx == MC);
      if (load_ok)
        outputMatchCount <= '0;
      else if (m_nx == MC && m != MC && outputMatchCount != 8'hFF)
        outputMatchCount <= outputMatchCount + 8'd1;
    end
  end
`else
  assign outputExpZ       = 1'b0;
  assign outputMatchCount = '0;
`endif

endmodule

// File: tb/tb_serial_w_gen.sv
// Directed bench for serial_w_gen.
// Drives on the falling edge, samples on the falling edge.
module tb_serial_w_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [15:0] pat;
  logic [4:0]  len;
  logic        w;
  logic        valid;
  logic        busy;
  logic        done;
  logic        expz;
  logic [7:0]  mcnt;

  int n_run  = 0;
  int n_fail = 0;

  serial_w_gen #(.WIDTH(16), .LEN_W(5)) dut (
    .inputClk         (clk),
    .inputReset       (rst),
    .inputLoad        (load),
    .inputPattern     (pat),
    .inputLength      (len),
    .outputW          (w),
    .outputValid      (valid),
    .outputBusy       (busy),
    .outputDone       (done),
    .outputExpZ       (expz),
    .outputMatchCount (mcnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Called at a falling edge while idle; checks a full transfer.
  task automatic xfer(input string tag,
                      input logic [15:0] p,
                      input logic [4:0] l,
                      input int n,
                      input int seq[16]);
    pat  = p;
    len  = l;
    load = 1'b1;
    step();
    load = 1'b0;
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s.w%0d", tag, i), 32'(w), 32'(seq[i]));
      chk($sformatf("%s.v%0d", tag, i), 32'(valid), 1);
      chk($sformatf("%s.b%0d", tag, i), 32'(busy), 1);
      chk($sformatf("%s.d%0d", tag, i), 32'(done), 0);
      step();
    end
    chk({tag, ".done"}, 32'(done), 1);
    chk({tag, ".dbusy"}, 32'(busy), 1);
    chk({tag, ".dvalid"}, 32'(valid), 0);
    chk({tag, ".dw"}, 32'(w), 0);
    step();
    chk({tag, ".idone"}, 32'(done), 0);
    chk({tag, ".ibusy"}, 32'(busy), 0);
  endtask

  int s36[16] = '{0,1,1,0,1,1,0,0,0,0,0,0,0,0,0,0};
  int sa5[16] = '{1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1};
  int s05[16] = '{1,0,1,0,0,0,0,0,0,0,0,0,0,0,0,0};
  int sdb[10] = '{1,1,0,1,1,0,1,1,0,0};
  int zdb[10] = '{0,0,1,0,0,1,0,0,1,0};

  initial begin
    rst  = 1'b1;
    load = 1'b0;
    pat  = '0;
    len  = '0;
    step();
    chk("rst.w", 32'(w), 0);
    chk("rst.valid", 32'(valid), 0);
    chk("rst.busy", 32'(busy), 0);
    chk("rst.done", 32'(done), 0);
    chk("rst.expz", 32'(expz), 0);
    chk("rst.mcnt", 32'(mcnt), 0);
    rst = 1'b0;
    step();

    xfer("p36", 16'h0036, 5'd8, 8, s36);
    xfer("len0", 16'hFFFF, 5'd0, 0, s36);
    xfer("len31", 16'hA5C3, 5'd31, 16, sa5);

    // Loads during SHIFT and DONE must be dropped.
    pat  = 16'h0036;
    len  = 5'd8;
    load = 1'b1;
    step();
    load = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("ign.w%0d", i), 32'(w), 32'(s36[i]));
      chk($sformatf("ign.v%0d", i), 32'(valid), 1);
      if (i == 2) begin
        pat  = 16'hFFFF;
        len  = 5'd4;
        load = 1'b1;
      end else begin
        load = 1'b0;
      end
      step();
    end
    chk("ign.done", 32'(done), 1);
    pat  = 16'hFFFF;
    len  = 5'd4;
    load = 1'b1;
    step();
    chk("ign.idlebusy", 32'(busy), 0);
    chk("ign.idlevalid", 32'(valid), 0);
    xfer("reload", 16'h0005, 5'd3, 3, s05);

    // Abort at bit 3.
    pat  = 16'h0036;
    len  = 5'd8;
    load = 1'b1;
    step();
    load = 1'b0;
    step();
    step();
    step();
    chk("abort.pre", 32'(busy), 1);
    rst = 1'b1;
    #1;
    chk("abort.w", 32'(w), 0);
    chk("abort.valid", 32'(valid), 0);
    chk("abort.busy", 32'(busy), 0);
    chk("abort.done", 32'(done), 0);
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("abort.nd%0d", i), 32'(done), 0);
      chk($sformatf("abort.nb%0d", i), 32'(busy), 0);
      step();
    end

    // Post-abort load, also exercising the z model.
    pat  = 16'h00DB;
    len  = 5'd8;
    load = 1'b1;
    step();
    load = 1'b0;
    for (int c = 0; c < 10; c++) begin
      chk($sformatf("db.w%0d", c), 32'(w), 32'(sdb[c]));
`ifdef EXPECT_Z_EN
      chk($sformatf("db.z%0d", c), 32'(expz), 32'(zdb[c]));
`else
      chk($sformatf("db.z%0d", c), 32'(expz), 0);
`endif
      if (c == 8) chk("db.done", 32'(done), 1);
      step();
    end
`ifdef EXPECT_Z_EN
    chk("db.mcnt", 32'(mcnt), 3);
`else
    chk("db.mcnt", 32'(mcnt), 0);
`endif
    chk("db.busy", 32'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
